// File: rtl/sram_arbiter.sv
// Three-port arbiter for the shared 16-bit async SRAM (A: cpu data, B: ifetch, V: framebuffer).
// Define MEM_ARB_VGA_EN to enable port V at top priority; otherwise A/B round-robin only.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aReq,
    input  logic        aWe,
    input  logic [17:0] aAddr,
    input  logic [15:0] aWdata,
    output logic        aAck,
    output logic [15:0] aRdata,
    input  logic        bReq,
    input  logic [17:0] bAddr,
    output logic        bAck,
    output logic [15:0] bRdata,
    input  logic        vReq,
    input  logic [17:0] vAddr,
    output logic        vAck,
    output logic [15:0] vRdata,
    inout  wire  [15:0] memDataBus,
    output logic [17:0] memAddrBus,
    output logic        memEnable,
    output logic        memRead,
    output logic        memWrite
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} stateT;
    typedef enum logic [1:0] {GRANT_A, GRANT_B, GRANT_V} grantT;

    localparam logic [3:0] LAST_CYCLE = 4'(WAIT_CYCLES - 1);

    stateT       state;
    grantT       grant;
    grantT       lastAB;
    logic [3:0]  cnt;
    logic        weQ;
    logic [15:0] wdataQ;
    logic        driveEn;
    logic        vWins;
    logic        pickA;
    logic        anyReq;

`ifdef MEM_ARB_VGA_EN
    assign vWins = vReq;
`else
    logic unusedVReq;
    assign unusedVReq = vReq;
    assign vWins = 1'b0;
`endif

    assign anyReq = vWins | aReq | bReq;
    assign pickA  = aReq & (~bReq | (lastAB == GRANT_B));

    assign memDataBus = driveEn ? wdataQ : 16'hzzzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GRANT_A;
            lastAB     <= GRANT_B;
            cnt        <= 4'd0;
            weQ        <= 1'b0;
            wdataQ     <= 16'h0000;
            driveEn    <= 1'b0;
            memAddrBus <= 18'h0;
            memEnable  <= 1'b1;
            memRead    <= 1'b1;
            memWrite   <= 1'b1;
            aAck       <= 1'b0;
            bAck       <= 1'b0;
            vAck       <= 1'b0;
            aRdata     <= 16'h0000;
            bRdata     <= 16'h0000;
            vRdata     <= 16'h0000;
        end else begin
            aAck <= 1'b0;
            bAck <= 1'b0;
            vAck <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (anyReq) begin
                        state     <= SETUP;
                        cnt       <= 4'd0;
                        memEnable <= 1'b0;
                        if (vWins) begin
                            grant      <= GRANT_V;
                            memAddrBus <= vAddr;
                            weQ        <= 1'b0;
                            memRead    <= 1'b0;
                        end else if (pickA) begin
                            grant      <= GRANT_A;
                            lastAB     <= GRANT_A;
                            memAddrBus <= aAddr;
                            weQ        <= aWe;
                            wdataQ     <= aWdata;
                            memRead    <= aWe;
                            driveEn    <= aWe;
                        end else begin
                            grant      <= GRANT_B;
                            lastAB     <= GRANT_B;
                            memAddrBus <= bAddr;
                            weQ        <= 1'b0;
                            memRead    <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    // address has now been stable a full cycle, safe to strobe WE
                    state    <= ACCESS;
                    memWrite <= ~weQ;
                end
                ACCESS: begin
                    if (cnt == LAST_CYCLE) begin
                        state     <= DONE;
                        memEnable <= 1'b1;
                        memRead   <= 1'b1;
                        memWrite  <= 1'b1;
                        if (grant == GRANT_V) begin
                            vAck <= 1'b1;
                            if (!weQ) vRdata <= memDataBus;
                        end else if (grant == GRANT_A) begin
                            aAck <= 1'b1;
                            if (!weQ) aRdata <= memDataBus;
                        end else begin
                            bAck <= 1'b1;
                            if (!weQ) bRdata <= memDataBus;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    driveEn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed timing cases plus randomized traffic
// checked against a transaction-level memory model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        aReq, aWe, bReq, vReq;
    logic [17:0] aAddr, bAddr, vAddr;
    logic [15:0] aWdata;
    logic        aAck, bAck, vAck;
    logic [15:0] aRdata, bRdata, vRdata;
    wire  [15:0] memDataBus;
    logic [17:0] memAddrBus;
    logic        memEnable, memRead, memWrite;

    logic [15:0] sram [256];
    logic [15:0] refMem [64];
    logic        sramLoad;
    logic        probe;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lastAck = -100;
    bit monOn = 0;

`ifdef MEM_ARB_VGA_EN
    int expOrd[$] = '{2, 0, 1};
    int expCyc[$] = '{4, 9, 14};
`else
    int expOrd[$] = '{0, 1};
    int expCyc[$] = '{4, 9};
`endif

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .aReq(aReq), .aWe(aWe), .aAddr(aAddr), .aWdata(aWdata),
        .aAck(aAck), .aRdata(aRdata),
        .bReq(bReq), .bAddr(bAddr), .bAck(bAck), .bRdata(bRdata),
        .vReq(vReq), .vAddr(vAddr), .vAck(vAck), .vRdata(vRdata),
        .memDataBus(memDataBus), .memAddrBus(memAddrBus),
        .memEnable(memEnable), .memRead(memRead), .memWrite(memWrite)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] sramInit(input int i);
        return 16'((i * 4951) ^ 16'hA5A5);
    endfunction

    // async SRAM model; probe drives a marker to prove the DUT released the bus
    assign memDataBus = (!memEnable && !memRead) ? sram[memAddrBus[7:0]]
                      : (probe ? 16'h5A3C : 16'hzzzz);

    always @(posedge clk) begin
        if (sramLoad) begin
            for (int i = 0; i < 256; i++) sram[i] <= sramInit(i);
        end else if (!memEnable && !memWrite) begin
            sram[memAddrBus[7:0]] <= memDataBus;
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        aReq = 1'b0; bReq = 1'b0; vReq = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic doTxn(input int p, input logic we, input logic [17:0] addr,
                         input logic [15:0] wd);
        int n = 0;
        logic got = 1'b0;
        logic [15:0] rd;
        case (p)
            0: begin aWe = we; aAddr = addr; aWdata = wd; aReq = 1'b1; end
            1: begin bAddr = addr; bReq = 1'b1; end
            default: begin vAddr = addr; vReq = 1'b1; end
        endcase
        while (!got && n < 300) begin
            tick();
            n++;
            got = (p == 0) ? aAck : (p == 1) ? bAck : vAck;
        end
        checkEq($sformatf("ack%0d", p), 32'(got), 1);
        if (got) begin
            rd = (p == 0) ? aRdata : (p == 1) ? bRdata : vRdata;
            if (we) refMem[addr[5:0]] = wd;
            else checkEq($sformatf("rd%0d@%0h", p, addr), 32'(rd),
                         32'(refMem[addr[5:0]]));
        end
        case (p)
            0: aReq = 1'b0;
            1: bReq = 1'b0;
            default: vReq = 1'b0;
        endcase
    endtask

    initial begin
        forever begin
            tick();
            if (monOn && (aAck || bAck || vAck)) begin
                checkEq("ackOne", 32'(int'(aAck) + int'(bAck) + int'(vAck)), 1);
                checkEq("ackGap", 32'(cyc - lastAck >= 5), 1);
`ifndef MEM_ARB_VGA_EN
                checkEq("vAckOff", 32'(vAck), 0);
`endif
                lastAck = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int wl, rl, ackC, ackN;
        int ord[$];
        int at[$];
        rst = 1'b1; probe = 1'b0; sramLoad = 1'b1;
        aReq = 1'b0; bReq = 1'b0; vReq = 1'b0; aWe = 1'b0;
        aAddr = '0; bAddr = '0; vAddr = '0; aWdata = '0;
        for (int i = 0; i < 64; i++) refMem[i] = sramInit(i);
        tick();
        sramLoad = 1'b0;
        tick();
        checkEq("rstEn", 32'(memEnable), 1);
        checkEq("rstRd", 32'(memRead), 1);
        checkEq("rstWr", 32'(memWrite), 1);
        checkEq("rstAddr", 32'(memAddrBus), 0);
        checkEq("rstAcks", 32'({aAck, bAck, vAck}), 0);
        checkEq("rstRdata", 32'(aRdata | bRdata | vRdata), 0);
        probe = 1'b1; #1;
        checkEq("rstBusZ", 32'(memDataBus), 32'h5A3C);
        probe = 1'b0;
        rst = 1'b0;

        // uncontended write
        aWe = 1'b1; aAddr = 18'h10; aWdata = 16'hBEEF; aReq = 1'b1;
        wl = 0; ackC = 0; ackN = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (!memWrite) begin
                wl++;
                checkEq("wrAddrLow", 32'(memAddrBus), 32'h10);
            end
            if (aAck) begin ackN++; if (ackC == 0) ackC = c; end
            if (c == 1) begin
                checkEq("wrSetupEn", 32'(memEnable), 0);
                checkEq("wrSetupWe", 32'(memWrite), 1);
                checkEq("wrSetupAddr", 32'(memAddrBus), 32'h10);
                checkEq("wrSetupBus", 32'(memDataBus), 32'hBEEF);
            end
            if (c == 4) begin
                checkEq("wrDoneEn", 32'(memEnable), 1);
                checkEq("wrHoldBus", 32'(memDataBus), 32'hBEEF);
                checkEq("wrDoneAddr", 32'(memAddrBus), 32'h10);
                aReq = 1'b0;
            end
            if (c == 5) begin
                probe = 1'b1; #1;
                checkEq("wrBusZ", 32'(memDataBus), 32'h5A3C);
                probe = 1'b0;
            end
        end
        checkEq("wrLowCycles", 32'(wl), 2);
        checkEq("wrAckCycle", 32'(ackC), 4);
        checkEq("wrAckCount", 32'(ackN), 1);
        refMem[16] = 16'hBEEF;

        // read back
        aWe = 1'b0; aReq = 1'b1;
        rl = 0; ackC = 0; ackN = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (!memRead) rl++;
            if (aAck) begin
                ackN++; ackC = c; aReq = 1'b0;
                checkEq("rdData", 32'(aRdata), 32'hBEEF);
            end
            if (c == 6) checkEq("rdHold", 32'(aRdata), 32'hBEEF);
        end
        checkEq("rdLowCycles", 32'(rl), 3);
        checkEq("rdAckCycle", 32'(ackC), 4);
        checkEq("rdAckCount", 32'(ackN), 1);

        // A and B held together: A,B,A,B five clocks apart
        resetDut();
        aWe = 1'b0; aAddr = 18'h1; bAddr = 18'h2;
        aReq = 1'b1; bReq = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (aAck) begin ord.push_back(0); at.push_back(c); end
            if (bAck) begin ord.push_back(1); at.push_back(c); end
        end
        aReq = 1'b0; bReq = 1'b0;
        checkEq("altCount", 32'(ord.size()), 4);
        for (int i = 0; i < 4 && i < ord.size(); i++) begin
            checkEq($sformatf("altOrd%0d", i), 32'(ord[i]), 32'(i % 2));
            checkEq($sformatf("altCyc%0d", i), 32'(at[i]), 32'(4 + 5 * i));
        end

        // V, A, B raised together
        resetDut();
        ord.delete(); at.delete();
        aWe = 1'b0; aAddr = 18'h3; bAddr = 18'h4; vAddr = 18'h5;
        aReq = 1'b1; bReq = 1'b1; vReq = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (aAck) begin ord.push_back(0); at.push_back(c); aReq = 1'b0; end
            if (bAck) begin ord.push_back(1); at.push_back(c); bReq = 1'b0; end
            if (vAck) begin ord.push_back(2); at.push_back(c); vReq = 1'b0; end
        end
        aReq = 1'b0; bReq = 1'b0; vReq = 1'b0;
        checkEq("vabCount", 32'(ord.size()), 32'(expOrd.size()));
        for (int i = 0; i < expOrd.size() && i < ord.size(); i++) begin
            checkEq($sformatf("vabOrd%0d", i), 32'(ord[i]), 32'(expOrd[i]));
            checkEq($sformatf("vabCyc%0d", i), 32'(at[i]), 32'(expCyc[i]));
        end

        // reset during ACCESS of a write
        resetDut();
        aWe = 1'b1; aAddr = 18'h20; aWdata = 16'h1234; aReq = 1'b1;
        tick();
        tick();
        checkEq("mrWeLow", 32'(memWrite), 0);
        rst = 1'b1; probe = 1'b1;
        #1;
        checkEq("mrWeHigh", 32'(memWrite), 1);
        checkEq("mrEnHigh", 32'(memEnable), 1);
        checkEq("mrBusZ", 32'(memDataBus), 32'h5A3C);
        checkEq("mrNoAck0", 32'(aAck), 0);
        probe = 1'b0;
        tick();
        checkEq("mrNoAck1", 32'(aAck), 0);
        tick();
        rst = 1'b0;
        ackC = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (aAck && ackC == 0) begin ackC = c; aReq = 1'b0; end
        end
        aReq = 1'b0;
        checkEq("mrAckCycle", 32'(ackC), 4);
        refMem[32] = 16'h1234;

        // randomized traffic against the reference memory
        tick();
        monOn = 1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    doTxn(0, 1'($urandom_range(0, 1)), 18'($urandom_range(0, 63)),
                          16'($urandom));
                end
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    doTxn(1, 1'b0, 18'($urandom_range(0, 63)), 16'h0);
                end
            end
`ifdef MEM_ARB_VGA_EN
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(2, 5)) tick();
                    doTxn(2, 1'b0, 18'($urandom_range(0, 63)), 16'h0);
                end
            end
`endif
        join
        tick();
        monOn = 0;
`ifndef MEM_ARB_VGA_EN
        checkEq("vRdataOff", 32'(vRdata), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external 16-bit asynchronous SRAM between three requesters: CPU data port A (read/write), CPU instruction-fetch port B (read-only) and the graphics card's framebuffer port V (read-only). It sits between the cpu/GraphicCard instances and the board's SRAM pins, and serialises their accesses. It generates the chip enable, output enable and write enable strobes and the tristate control for the shared data bus.

## Interface
Parameters:
- WAIT_CYCLES, 2, length of the ACCESS phase in clocks (legal range 1..15).

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- aReq  in  1  port A request; held high until aAck
- aWe  in  1  port A write (1) / read (0); held stable with aReq
- aAddr  in  18  port A word address
- aWdata  in  16  port A write data
- aAck  out  1  one-cycle completion pulse for port A
- aRdata  out  16  port A read data
- bReq, bAddr[17:0], bAck, bRdata[15:0]: same as port A, read-only
- vReq, vAddr[17:0], vAck, vRdata[15:0]: same as port A, read-only
- memDataBus  inout  16  SRAM data; high-Z unless a write is in progress
- memAddrBus  out  18  SRAM address
- memEnable  out  1  SRAM chip enable, active-low
- memRead  out  1  SRAM output enable, active-low
- memWrite  out  1  SRAM write enable, active-low

## Operation
- FSM states and transitions:
  - IDLE → SETUP when any request is present.
  - SETUP → ACCESS.
  - ACCESS is held for WAIT_CYCLES clocks, then → DONE.
  - DONE → IDLE.
- In IDLE the arbiter samples the request lines.
  - Priority: V wins over A and B.
  - A and B alternate round-robin via the flag lastAB. After reset lastAB=B, so A wins the first A/B tie.
  - When one port wins, the arbiter latches the grant, address, we and wdata into internal registers.
- SETUP:
  - memEnable=0 and memAddrBus = latched address.
  - On a read, memRead=0.
  - On a write, memDataBus is driven with wdata and memWrite stays 1.
- ACCESS:
  - Address, enable and drive are as in SETUP.
  - On a write, memWrite=0 throughout ACCESS.
  - On the last ACCESS edge, a read captures memDataBus into the granted port's rdata register.
- DONE:
  - memEnable=1, memRead=1, memWrite=1.
  - Write data keeps being driven (hold time) and is released on entry to IDLE.
  - The granted port's ack is 1 for exactly this cycle.
- rdata registers hold their value until the next completed read on the same port.
- Requests are level-based. If a port keeps req high in the cycle after its ack, that is a new request and is arbitrated normally.
- Ungranted ports wait without limit. Round-robin guarantees A and B each get a turn. V can starve A and B only if it requests continuously.

## Timing
- Uncontended read or write: req seen in IDLE at edge 0, ack high in cycle 2+WAIT_CYCLES. With WAIT_CYCLES=2 the ack is 4 cycles after the request.
- Back-to-back throughput: one access per 3+WAIT_CYCLES clocks, because DONE always returns to IDLE.
- Reset values: state IDLE; memEnable=1, memRead=1, memWrite=1; memAddrBus=0; memDataBus high-Z; all acks 0; all rdata 0; lastAB=B.
- Reset mid-access: outputs go to reset values immediately. The access is abandoned with no ack, and the requester re-arbitrates after reset.
- memWrite never falls in the same cycle as an address change. Address is stable for one SETUP cycle before memWrite falls and for the DONE cycle after it rises.
- Simultaneous A+B+V: the V access comes first. Then A and B are served in order, starting with whichever of A/B lastAB favours.

## Configuration
- MEM_ARB_VGA_EN defined: port V is present and has the highest priority, as described above.
- MEM_ARB_VGA_EN undefined:
  - vReq is ignored; vAck=0 and vRdata=0 permanently.
  - Arbitration is pure A/B round-robin.
  - The port list is unchanged.

## Test plan
- Reset, then aReq with aWe=1, aAddr=0x00010, aWdata=0xBEEF (WAIT_CYCLES=2) → memWrite low for exactly 2 cycles with address 0x00010; aAck in cycle 4; bus high-Z afterwards.
- A then reads 0x00010 with the SRAM model returning 0xBEEF → memRead low for 3 cycles; aAck in cycle 4 with aRdata=0xBEEF held afterwards.
- aReq and bReq high together continuously → grants alternate A,B,A,B, starting with A; each ack is a single cycle, 5 clocks apart.
- vReq, aReq and bReq all raised in the same cycle (MEM_ARB_VGA_EN defined) → order V, A, B. Same stimulus with the macro undefined → order A, B, vAck never asserts.
- rst asserted during ACCESS of a write → memWrite=1, memEnable=1 and bus high-Z in the same cycle with no clock edge needed; no aAck; after rst drops, the held aReq completes normally.
